// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Receive-side controller between UART_Rx and the core MMIO bus.
//            Detects the frame-complete edge, latches the 9-bit frame,
//            checks parity, queues good bytes in a first-word-fall-through
//            FIFO and reports sticky error flags plus an interrupt request.
// Ports    : clk, n_rst (async active-low)
//            rx_done_i, rx_frame_i[8:0]   - receiver handshake and frame
//            rd_en_i, clr_err_i           - core pop / error clear
//            data_o, valid_o, count_o     - FIFO head, not-empty, occupancy
//            parity_err_o, overrun_err_o  - sticky error flags
//            irq_o                        - valid_o | any error flag
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_done_i,
    input  logic [8:0]        rx_frame_i,
    input  logic              rd_en_i,
    input  logic              clr_err_i,
    output logic [7:0]        data_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   count_o,
    output logic              parity_err_o,
    output logic              overrun_err_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   C_FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE    = ADDR_W'(1);

    state_t              state_q,       state_d;
    logic                rx_done_q,     rx_done_d;
    logic [8:0]          frame_q,       frame_d;
    logic                perr_q,        perr_d;
    logic [7:0]          mem_q [DEPTH], mem_d [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q,      wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,      rd_ptr_d;
    logic [ADDR_W:0]     count_q,       count_d;
    logic                parity_err_q,  parity_err_d;
    logic                overrun_err_q, overrun_err_d;

    logic w_start;
    logic w_pop;
    logic w_push;
    logic w_full;
    logic w_set_perr;
    logic w_set_ovr;
    logic w_parity_exp;

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        perr_d        = perr_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rx_done_d     = rx_done_i;

        w_start       = rx_done_i & ~rx_done_q;
        w_pop         = rd_en_i & (count_q != '0);
        w_full        = (count_q == C_FULL_COUNT);
        w_push        = 1'b0;
        w_set_perr    = 1'b0;
        w_set_ovr     = 1'b0;
        w_parity_exp  = PARITY_ODD ? ~(^frame_q[7:0]) : (^frame_q[7:0]);

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    frame_d = rx_frame_i;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                perr_d  = (frame_q[8] != w_parity_exp);
                state_d = ST_CHECK;
                // A second frame arriving while busy cannot be latched.
                if (w_start) begin
                    w_set_ovr = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_start) begin
                    w_set_ovr = 1'b1;
                end
                if (perr_q) begin
                    w_set_perr = 1'b1;
                end else if (w_full && !w_pop) begin
                    w_set_ovr = 1'b1;
                end else begin
                    // Full with a same-edge pop still has room for the push.
                    w_push = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_push) begin
            mem_d[wr_ptr_q] = frame_q[7:0];
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - C_CNT_ONE;
        end

        // Set has priority over a simultaneous clear.
        parity_err_d  = w_set_perr | (parity_err_q  & ~clr_err_i);
        overrun_err_d = w_set_ovr  | (overrun_err_q & ~clr_err_i);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            // Resetting high keeps a level already present at release
            // from being seen as a new frame.
            rx_done_q     <= 1'b1;
            frame_q       <= '0;
            perr_q        <= 1'b0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_done_q     <= rx_done_d;
            frame_q       <= frame_d;
            perr_q        <= perr_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign valid_o       = (count_q != '0);
    assign count_o       = count_q;
    assign parity_err_o  = parity_err_q;
    assign overrun_err_o = overrun_err_q;
    assign irq_o         = valid_o | parity_err_q | overrun_err_q;

endmodule
`default_nettype wire
